// File: rtl/ccff_bitstream_loader.sv
// Feeds the tile configuration chain: prepends a sentinel header, serialises stream words MSB-first,
// and checks the sentinel as it returns from the chain tail to prove chain length and continuity.
module ccff_bitstream_loader #(
  parameter int                WORD_W    = 32,
  parameter int                CHAIN_LEN = 4096,
  parameter int                SENT_W    = 8,
  parameter logic [SENT_W-1:0] SENTINEL  = 8'hA5
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int TOTAL = CHAIN_LEN + SENT_W;
  localparam int NW    = $clog2(TOTAL + 1);
  localparam int CW    = $clog2(CHAIN_LEN + 1);
  localparam int BW    = $clog2(WORD_W + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  logic [2:0]        state;
  logic [NW-1:0]     n;
  logic [CW-1:0]     cfg_left;
  logic [WORD_W-1:0] buf_q;
  logic [BW-1:0]     buf_cnt;
  logic [SENT_W-1:0] hdr_sh;
  logic [SENT_W-1:0] tail_sh;
  logic              mismatch;

  logic hdr_last, shifting, need_more, hs, tail_chk, tail_bad, finish;

  // n counts bits already driven onto ccff_head, so whenever ccff_shift_en is high the bit
  // being shifted on this edge has index n-1; the tail carries header bits once n-1 >= CHAIN_LEN.
  always_comb begin
    busy      = (state == ST_HDR) || (state == ST_LOAD);
    hdr_last  = (state == ST_HDR) && (n == NW'(SENT_W - 1));
    shifting  = (state == ST_LOAD) && (buf_cnt != '0) && (cfg_left != '0);
    need_more = shifting ? (cfg_left > CW'(1)) : (cfg_left != '0);
    s_ready   = !abort && ((state == ST_LOAD) || hdr_last) &&
                ((buf_cnt == '0) || ((buf_cnt == BW'(1)) && shifting)) && need_more;
    hs        = s_valid && s_ready;
    tail_chk  = ccff_shift_en && (n > NW'(CHAIN_LEN));
    tail_bad  = tail_chk && (ccff_tail != tail_sh[SENT_W-1]);
    finish    = (state == ST_LOAD) && ccff_shift_en && (n == NW'(TOTAL));
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state         <= ST_IDLE;
      n             <= '0;
      cfg_left      <= '0;
      buf_q         <= '0;
      buf_cnt       <= '0;
      hdr_sh        <= '0;
      tail_sh       <= '0;
      mismatch      <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else if (abort) begin
      state         <= ST_IDLE;
      buf_cnt       <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      case (state)
        ST_HDR: begin
          ccff_head     <= hdr_sh[SENT_W-1];
          ccff_shift_en <= 1'b1;
          hdr_sh        <= hdr_sh << 1;
          n             <= n + NW'(1);
          mismatch      <= mismatch | tail_bad;
          if (tail_chk) tail_sh <= tail_sh << 1;
          if (hdr_last) state <= ST_LOAD;
          if (hs) begin
            buf_q   <= s_data;
            buf_cnt <= BW'(WORD_W);
          end
        end
        ST_LOAD: begin
          if (finish) begin
            ccff_shift_en <= 1'b0;
            ccff_head     <= 1'b0;
            buf_cnt       <= '0;
            if (mismatch || tail_bad) begin
              state <= ST_ERROR;
              error <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end else begin
            mismatch      <= mismatch | tail_bad;
            ccff_shift_en <= shifting;
            if (tail_chk) tail_sh <= tail_sh << 1;
            if (shifting) begin
              ccff_head <= buf_q[WORD_W-1];
              buf_q     <= buf_q << 1;
              buf_cnt   <= buf_cnt - BW'(1);
              n         <= n + NW'(1);
              cfg_left  <= cfg_left - CW'(1);
            end
            // A refill overrides the drained buffer, giving back-to-back shifts across words.
            if (hs) begin
              buf_q   <= s_data;
              buf_cnt <= BW'(WORD_W);
            end
          end
        end
        default: begin
          ccff_shift_en <= 1'b0;
          if (start) begin
            state    <= ST_HDR;
            n        <= '0;
            cfg_left <= CW'(CHAIN_LEN);
            buf_cnt  <= '0;
            hdr_sh   <= SENTINEL;
            tail_sh  <= SENTINEL;
            mismatch <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Randomised scoreboard bench for ccff_bitstream_loader driving a behavioural configuration chain
// whose length can be made one bit short to provoke a sentinel error.
module tb_ccff_bitstream_loader;

  localparam int                WORD_W    = 32;
  localparam int                CHAIN_LEN = 40;
  localparam int                SENT_W    = 8;
  localparam logic [SENT_W-1:0] SENTINEL  = 8'hA5;
  localparam int                TOTAL     = CHAIN_LEN + SENT_W;
  localparam int                NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  logic              prog_clk;
  logic              prog_reset_n;
  logic              start;
  logic              abort;
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic              error;

  ccff_bitstream_loader #(
    .WORD_W   (WORD_W),
    .CHAIN_LEN(CHAIN_LEN),
    .SENT_W   (SENT_W),
    .SENTINEL (SENTINEL)
  ) dut (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .start        (start),
    .abort        (abort),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  // Behavioural configuration chain; short_chain removes the last cell.
  logic [CHAIN_LEN-1:0] chain;
  bit                   short_chain;
  initial chain = '0;
  assign ccff_tail = short_chain ? chain[CHAIN_LEN-2] : chain[CHAIN_LEN-1];
  always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};

  longint cyc = 0;
  always @(posedge prog_clk) cyc <= cyc + 1;

  typedef struct {
    logic [CHAIN_LEN-1:0] chain;
    bit                   exp_done;
    bit                   check_chain;
    int                   latency;
    longint               stamp;
    int                   shift_snap;
    int                   hs_snap;
  } exp_t;

  exp_t res_q[$];
  bit   bitq[$];
  int   checks = 0;
  int   failures = 0;
  int   shift_total = 0;
  int   hs_total = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: samples late in the low phase, checks every shifted bit and every completed load.
  initial begin
    bit prev_fin;
    bit fin;
    bit exp_b;
    exp_t e;
    prev_fin = 1'b0;
    forever begin
      @(negedge prog_clk);
      #3;
      if (!prog_reset_n) begin
        prev_fin = 1'b0;
        continue;
      end
      if (ccff_shift_en) begin
        shift_total++;
        if (bitq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_shift actual=%0d required=0 extra shifts", 1);
        end else begin
          exp_b = bitq.pop_front();
          check_output("head_bit", 64'(ccff_head), 64'(exp_b));
        end
      end
      if (s_valid && s_ready) hs_total++;
      fin = done || error;
      if (fin && !prev_fin) begin
        if (res_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_completion actual=%0d required=0", 1);
        end else begin
          e = res_q.pop_front();
          check_output("done_flag", 64'(done), 64'(e.exp_done));
          check_output("error_flag", 64'(error), 64'(!e.exp_done));
          check_output("busy_at_end", 64'(busy), 64'(0));
          check_output("shift_count", 64'(shift_total - e.shift_snap), 64'(TOTAL));
          check_output("handshakes", 64'(hs_total - e.hs_snap), 64'(NWORDS));
          check_output("latency", 64'(cyc - e.stamp - 1), 64'(e.latency));
          if (e.check_chain) check_output("chain_contents", 64'(chain), 64'(e.chain));
        end
      end
      prev_fin = fin;
    end
  end

  task automatic apply_stimulus(input bit directed, input int stall_len, input bit short_mode,
                                input int abort_at, input int ign_at, input int rst_at);
    logic [WORD_W-1:0] words [NWORDS+2];
    exp_t e;
    int   widx;
    int   stall_left;
    bit   finished;
    bit   tracked;
    widx       = 0;
    stall_left = stall_len;
    finished   = 1'b0;
    tracked    = (abort_at < 0) && (rst_at < 0);
    for (int i = 0; i < NWORDS + 2; i++) words[i] = $urandom();
    if (directed) begin
      words[0] = 32'hDEADBEEF;
      words[1] = 32'h12345678;
    end
    short_chain = short_mode;
    // Reference: the chain keeps the first CHAIN_LEN stream bits, the first one at the far end.
    e.chain = '0;
    for (int i = 0; i < CHAIN_LEN; i++)
      e.chain[CHAIN_LEN-1-i] = words[i / WORD_W][WORD_W-1-(i % WORD_W)];
    e.exp_done    = !short_mode;
    e.check_chain = !short_mode;
    e.latency     = TOTAL + 1 + stall_len;
    @(negedge prog_clk);
    e.stamp      = cyc;
    e.shift_snap = shift_total;
    e.hs_snap    = hs_total;
    for (int i = 0; i < SENT_W; i++) bitq.push_back(SENTINEL[SENT_W-1-i]);
    for (int i = 0; i < CHAIN_LEN; i++) bitq.push_back(e.chain[CHAIN_LEN-1-i]);
    if (tracked) res_q.push_back(e);
    for (int cnt = 0; cnt < 400 && !finished; cnt++) begin
      start   = (cnt == 0) || (cnt == ign_at);
      abort   = (cnt == abort_at);
      s_data  = words[(widx < NWORDS + 2) ? widx : NWORDS + 1];
      s_valid = 1'b1;
      #1;
      if (s_ready && widx == 1 && stall_left > 0) begin
        s_valid = 1'b0;
        stall_left--;
      end
      if (s_valid && s_ready) widx++;
      if (cnt == rst_at) begin
        #1;
        prog_reset_n = 1'b0;
        start = 1'b0;
        s_valid = 1'b0;
        #1;
        check_output("rst_s_ready", 64'(s_ready), 64'(0));
        check_output("rst_head", 64'(ccff_head), 64'(0));
        check_output("rst_shift_en", 64'(ccff_shift_en), 64'(0));
        check_output("rst_busy", 64'(busy), 64'(0));
        check_output("rst_done", 64'(done), 64'(0));
        check_output("rst_error", 64'(error), 64'(0));
        bitq.delete();
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        return;
      end
      @(negedge prog_clk);
      if (cnt == abort_at) begin
        start = 1'b0;
        abort = 1'b0;
        s_valid = 1'b0;
        #1;
        check_output("abort_busy", 64'(busy), 64'(0));
        check_output("abort_shift_en", 64'(ccff_shift_en), 64'(0));
        check_output("abort_s_ready", 64'(s_ready), 64'(0));
        check_output("abort_done", 64'(done), 64'(0));
        #1;
        bitq.delete();
        return;
      end
      if (done || error) finished = 1'b1;
    end
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b0;
    if (!finished) begin
      checks++;
      failures++;
      $display("[TB] FAIL load_timeout actual=busy required=done_or_error within 400 cycles");
      bitq.delete();
      if (tracked && res_q.size() > 0) void'(res_q.pop_back());
    end else if (directed) begin
      #1;
      check_output("chain_directed", 64'(chain), 64'(40'hDEADBEEF12));
    end
  endtask

  initial begin
    prog_reset_n = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    short_chain  = 1'b0;
    repeat (2) @(negedge prog_clk);
    #1;
    check_output("reset_s_ready", 64'(s_ready), 64'(0));
    check_output("reset_head", 64'(ccff_head), 64'(0));
    check_output("reset_shift_en", 64'(ccff_shift_en), 64'(0));
    check_output("reset_busy", 64'(busy), 64'(0));
    check_output("reset_done", 64'(done), 64'(0));
    check_output("reset_error", 64'(error), 64'(0));
    @(negedge prog_clk);
    prog_reset_n = 1'b1;

    apply_stimulus(1'b1, 0, 1'b0, -1, -1, -1);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 0, 1'b0, -1, -1, -1);
    apply_stimulus(1'b0, 5, 1'b0, -1, -1, -1);
    for (int i = 0; i < 2; i++) apply_stimulus(1'b0, int'($urandom_range(1, 6)), 1'b0, -1, -1, -1);
    apply_stimulus(1'b0, 0, 1'b1, -1, -1, -1);
    apply_stimulus(1'b0, 0, 1'b0, -1, -1, -1);
    apply_stimulus(1'b0, 0, 1'b0, 21, -1, -1);
    apply_stimulus(1'b0, 0, 1'b0, -1, -1, -1);
    apply_stimulus(1'b0, 0, 1'b0, 3, -1, -1);
    apply_stimulus(1'b0, 0, 1'b0, -1, 5, -1);
    apply_stimulus(1'b0, 0, 1'b0, -1, 30, -1);
    apply_stimulus(1'b0, 0, 1'b0, -1, -1, 25);
    apply_stimulus(1'b0, 0, 1'b0, -1, -1, -1);

    // Start and abort together from DONE: abort must win.
    @(negedge prog_clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    check_output("start_abort_busy", 64'(busy), 64'(0));
    check_output("start_abort_done", 64'(done), 64'(0));
    check_output("start_abort_shift_en", 64'(ccff_shift_en), 64'(0));
    @(negedge prog_clk);
    #1;
    check_output("start_abort_stays_idle", 64'(busy), 64'(0));

    repeat (5) @(negedge prog_clk);
    check_output("bits_left_over", 64'(bitq.size()), 64'(0));
    check_output("results_left_over", 64'(res_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
